// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control unit: opcodes, FSM states,
// datapath mux/ALU select values and default field widths.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF   = 11;
  localparam int OPCODE_WIDTH_DEF = 5;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  localparam logic [1:0] SEL_A_ALU  = 2'b00;
  localparam logic [1:0] SEL_A_EXT  = 2'b01;
  localparam logic [1:0] SEL_A_MEM  = 2'b10;
  localparam logic [1:0] SEL_A_HOLD = 2'b11;

  localparam logic SEL_B_EXT = 1'b0;
  localparam logic SEL_B_MEM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/program_counter.sv
// Program counter: load has priority over increment; increment wraps modulo 2^WIDTH.
module program_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer for the accumulator CPU; every instruction is one
// FETCH cycle (IR load, PC+1) followed by one EXECUTE cycle (controls from IR).
//   state   | meaning
//   INIT    | one cycle after reset, clears accumulator and status flags
//   FETCH   | IR <= instruction at PC, PC <= PC+1
//   EXECUTE | decode IR opcode, drive datapath controls, resolve branches
//   HALT    | terminal, left only by reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
  input  logic                               clock_in,
  input  logic                               reset_n_in,
  input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
  input  logic                               flag_Z_in,
  input  logic                               flag_N_in,
  output logic [DATA_WIDTH-1:0]              program_memory_address_out,
  output logic [DATA_WIDTH-1:0]              operand_out,
  output logic                               op_alu_out,
  output logic [1:0]                         sel_A_out,
  output logic                               sel_B_out,
  output logic                               acc_wr_out,
  output logic                               status_wr_out,
  output logic                               acc_reset_out,
  output logic                               status_reset_out,
  output logic                               data_memory_wr_out,
  output logic                               halted_out
);

  state_t                               state;
  state_t                               next_state;
  logic [OPCODE_WIDTH+DATA_WIDTH-1:0]   ir;
  logic [OPCODE_WIDTH-1:0]              opcode;
  logic [DATA_WIDTH-1:0]                pc;
  logic                                 ir_load;
  logic                                 pc_inc;
  logic                                 pc_load;
  logic [1:0]                           sel_a;
  logic                                 sel_b;
  logic                                 op_alu;
  logic                                 acc_wr;
  logic                                 status_wr;
  logic                                 acc_reset;
  logic                                 status_reset;
  logic                                 dmem_wr;

  assign opcode = ir[DATA_WIDTH +: OPCODE_WIDTH];

  program_counter #(.WIDTH(DATA_WIDTH)) u_pc (
    .clk        (clock_in),
    .rst_n      (reset_n_in),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (ir[DATA_WIDTH-1:0]),
    .pc         (pc)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= ST_INIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (ir_load) begin
        ir <= instruction_in;
      end
    end
  end

  // Outputs are decoded from the registered state, so an async reset drops
  // any strobe in the same instant without waiting for a clock edge.
  always_comb begin
    next_state   = state;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    sel_a        = SEL_A_HOLD;
    sel_b        = SEL_B_EXT;
    op_alu       = ALU_ADD;
    acc_wr       = 1'b0;
    status_wr    = 1'b0;
    acc_reset    = 1'b0;
    status_reset = 1'b0;
    dmem_wr      = 1'b0;
    case (state)
      ST_INIT: begin
        acc_reset    = 1'b1;
        status_reset = 1'b1;
        next_state   = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load    = 1'b1;
        pc_inc     = 1'b1;
        next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        next_state = ST_FETCH;
        case (opcode)
          OPCODE_WIDTH'(OP_HLT):  next_state = ST_HALT;
          OPCODE_WIDTH'(OP_STO):  dmem_wr = 1'b1;
          OPCODE_WIDTH'(OP_LD): begin
            sel_a  = SEL_A_MEM;
            acc_wr = 1'b1;
          end
          OPCODE_WIDTH'(OP_LDI): begin
            sel_a  = SEL_A_EXT;
            acc_wr = 1'b1;
          end
          OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_ADDI),
          OPCODE_WIDTH'(OP_SUB), OPCODE_WIDTH'(OP_SUBI): begin
            sel_a     = SEL_A_ALU;
            sel_b     = (opcode == OPCODE_WIDTH'(OP_ADD) || opcode == OPCODE_WIDTH'(OP_SUB))
                        ? SEL_B_MEM : SEL_B_EXT;
            op_alu    = (opcode == OPCODE_WIDTH'(OP_SUB) || opcode == OPCODE_WIDTH'(OP_SUBI))
                        ? ALU_SUB : ALU_ADD;
            acc_wr    = 1'b1;
            status_wr = 1'b1;
          end
          OPCODE_WIDTH'(OP_BEQ):  pc_load = flag_Z_in;
          OPCODE_WIDTH'(OP_BNE):  pc_load = !flag_Z_in;
          OPCODE_WIDTH'(OP_BGT):  pc_load = !flag_Z_in && !flag_N_in;
          OPCODE_WIDTH'(OP_BGE):  pc_load = !flag_N_in;
          OPCODE_WIDTH'(OP_BLT):  pc_load = flag_N_in;
          OPCODE_WIDTH'(OP_BLE):  pc_load = flag_Z_in || flag_N_in;
          OPCODE_WIDTH'(OP_JMP):  pc_load = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_INIT;
    endcase
  end

  assign program_memory_address_out = pc;
  assign operand_out                = ir[DATA_WIDTH-1:0];
  assign op_alu_out                 = op_alu;
  assign sel_A_out                  = sel_a;
  assign sel_B_out                  = sel_b;
  assign acc_wr_out                 = acc_wr;
  assign status_wr_out              = status_wr;
  assign acc_reset_out              = acc_reset;
  assign status_reset_out           = status_reset;
  assign data_memory_wr_out         = dmem_wr;
  assign halted_out                 = (state == ST_HALT);

endmodule
